// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// sequencer state encoding and the R-type funct codes that select it.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  // Operation select presented on op_i by the execute-stage decode.
  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_DIVU  = 2'd1;
  localparam logic [1:0] OP_MTHI  = 2'd2;
  localparam logic [1:0] OP_MTLO  = 2'd3;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  // R-type funct fields that map onto the ops above.
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  // True for the ops that need the iterative datapath (and therefore stall).
  function automatic logic op_is_iter(input logic [1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

  // Decoder helper: funct field to op_i encoding (only meaningful for the
  // four funct codes above).
  function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
    logic [1:0] op;
    op = OP_MULTU;
    case (funct)
      FUNCT_MULTU: op = OP_MULTU;
      FUNCT_DIVU:  op = OP_DIVU;
      FUNCT_MTHI:  op = OP_MTHI;
      FUNCT_MTLO:  op = OP_MTLO;
      default:     op = OP_MULTU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Per-cycle datapath of the multiply/divide unit. A single 2*WIDTH shift
// register holds {partial product high, multiplier} for MULTU and
// {remainder, dividend/quotient} for DIVU; the result halves always come out
// as {HI, LO}. res_*_o show the value the register takes after the current
// step, so the sequencer can capture the final result on the last step edge.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_step;

  // One shift-add / restoring-subtract step, plus operand load on issue.
  always_comb begin
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;

    acc_hi   = acc_q[2*WIDTH-1:WIDTH];

    // Multiply: add multiplicand when the current multiplier bit is set,
    // keep the carry and shift the whole register right by one.
    mul_sum  = {1'b0, acc_hi} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_hi, acc_q[WIDTH-1:1]};

    // Divide: bring the next dividend bit into the remainder and try to
    // subtract the divisor. A usable difference must be non-negative and fit
    // back into WIDTH bits; otherwise the shifted remainder is kept.
    div_shift = {acc_hi, acc_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    div_fits  = ~(div_trial[WIDTH+1] | div_trial[WIDTH]);
    div_next  = div_fits ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    acc_step = is_div_q ? div_next : mul_next;

    if (load_i) begin
      is_div_d = (op_i == OP_DIVU);
      opnd_d   = (op_i == OP_DIVU) ? src2_i : src1_i;
      acc_d    = {{WIDTH{1'b0}}, ((op_i == OP_DIVU) ? src1_i : src2_i)};
    end else if (step_i) begin
      acc_d    = acc_step;
    end
  end

  assign res_hi_o = acc_step[2*WIDTH-1:WIDTH];
  assign res_lo_o = acc_step[WIDTH-1:0];

  // Datapath registers; cleared so a reset mid-run leaves no stale state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else begin
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// HI/LO arithmetic unit for the execute stage: MULTU/DIVU run iteratively
// for WIDTH cycles, MTHI/MTLO write HI/LO directly.
//
// Issue handshake: start_i/op_i are sampled on the rising edge and an issue
// is accepted only when the state is IDLE or DONE. stall_o is the back-
// pressure: it is high for the cycle a MULTU/DIVU is presented and for every
// RUN cycle, and the pipeline must hold its op (and not present a new one)
// while stall_o is high. done_o pulses for one cycle when HI/LO carry the
// fresh MULTU/DIVU result.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o,
  output logic [1:0]       state_o
);

  localparam int unsigned     CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             issue_ok;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign issue_ok  = start_i && (state_q != S_RUN);
  assign core_step = (state_q == S_RUN);

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (core_load),
    .step_i   (core_step),
    .op_i     (op_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  // Next state, iteration count and HI/LO/flag updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    core_load = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE is a one-cycle result window; fall back to IDLE unless a new
        // iterative op starts here.
        state_d = S_IDLE;
        if (issue_ok) begin
          case (op_i)
            OP_MTHI: hi_d = src1_i;
            OP_MTLO: lo_d = src1_i;
            default: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              core_load = 1'b1;
              dbz_d     = (op_i == OP_DIVU) && (src2_i == '0);
            end
          endcase
        end
      end
      S_RUN: begin
        // HI/LO stay untouched until the final step lands.
        if (cnt_q == LAST_ITER) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and architectural register state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;
  assign state_o       = state_q;
  assign stall_o       = (state_q == S_RUN) || (issue_ok && op_is_iter(op_i));

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a table of directed MULTU/DIVU
// vectors, hand-written corner sequences and randomized ops checked against
// a plain-arithmetic reference.
module tb_mult_div_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'd0;
  logic [W-1:0]  src1_i = '0;
  logic [W-1:0]  src2_i = '0;
  logic          busy_o, done_o, stall_o, div_by_zero_o;
  logic [W-1:0]  hi_o, lo_o;
  logic [1:0]    state_o;

  always #5 clk_i = ~clk_i;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .stall_o       (stall_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o),
    .state_o       (state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] model_hi  = '0;
  logic [W-1:0] model_lo  = '0;
  logic         model_dbz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain unsigned arithmetic, {HI,LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] p;
    if (op == OP_MULTU) begin
      p = 64'(a) * 64'(b);
    end else if (b == 0) begin
      p = {a, 32'hFFFF_FFFF};
    end else begin
      p = {a % b, a / b};
    end
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_i);
  endtask

  // Present a MULTU/DIVU for one edge; leaves the bench at the first RUN cycle.
  task automatic start_iter(input string name, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    #1;
    check({name, " stall_issue"}, 64'(stall_o), 64'd1);
    step();
    start_i = 1'b0;
    model_dbz = (op == OP_DIVU) && (b == 0);
    #1;
    check({name, " dbz_at_issue"}, 64'(div_by_zero_o), 64'(model_dbz));
    check({name, " busy_first"}, 64'(busy_o), 64'd1);
  endtask

  // Count RUN cycles (bounded), then check the DONE cycle. With noise set, an
  // MTHI is held on the inputs through RUN and must be ignored.
  task automatic wait_done(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input bit noise);
    int cnt;
    cnt = 0;
    while (busy_o && cnt < 40) begin
      check({name, " hi_hold"}, 64'(hi_o), 64'(model_hi));
      check({name, " lo_hold"}, 64'(lo_o), 64'(model_lo));
      check({name, " stall_run"}, 64'(stall_o), 64'd1);
      if (noise) begin
        op_i = OP_MTHI; src1_i = $urandom; start_i = 1'b1;
      end
      step();
      #1;
      cnt++;
    end
    start_i = 1'b0;
    #1;
    check({name, " run_cycles"}, 64'(cnt), 64'd32);
    check({name, " done"}, 64'(done_o), 64'd1);
    check({name, " hi"}, 64'(hi_o), 64'(eh));
    check({name, " lo"}, 64'(lo_o), 64'(el));
    check({name, " dbz"}, 64'(div_by_zero_o), 64'(model_dbz));
    check({name, " stall_done"}, 64'(stall_o), 64'd0);
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic finish_idle(input string name);
    step();
    #1;
    check({name, " done_drop"}, 64'(done_o), 64'd0);
    check({name, " idle_busy"}, 64'(busy_o), 64'd0);
    check({name, " idle_state"}, 64'(state_o), 64'(S_IDLE));
  endtask

  task automatic mt(input string name, input logic [1:0] op, input logic [W-1:0] data);
    op_i = op; src1_i = data; src2_i = $urandom; start_i = 1'b1;
    #1;
    check({name, " stall"}, 64'(stall_o), 64'd0);
    step();
    start_i = 1'b0;
    if (op == OP_MTHI) model_hi = data;
    else model_lo = data;
    #1;
    check({name, " hi"}, 64'(hi_o), 64'(model_hi));
    check({name, " lo"}, 64'(lo_o), 64'(model_lo));
    check({name, " no_done"}, 64'(done_o), 64'd0);
    check({name, " no_busy"}, 64'(busy_o), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [63:0]  r;
    int           sel;

    vecs.push_back('{"mul_ff",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{"div_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    vecs.push_back('{"div_7_100", OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0});
    vecs.push_back('{"div_by0",  OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"mul_after0", OP_MULTU, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{"mul_zero", OP_MULTU, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{"div_max1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"div_eq",   OP_DIVU, 32'h8000_0001, 32'h8000_0001, 32'd0, 32'd1, 1'b0});

    // Reset values while reset is held.
    repeat (3) step();
    #1;
    check("rst hi", 64'(hi_o), 64'd0);
    check("rst lo", 64'(lo_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst dbz", 64'(div_by_zero_o), 64'd0);
    check("rst stall", 64'(stall_o), 64'd0);
    check("rst state", 64'(state_o), 64'(S_IDLE));
    rst_i = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      start_iter(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
      check({vecs[i].name, " dbz_vec"}, 64'(div_by_zero_o), 64'(vecs[i].exp_dbz));
      finish_idle(vecs[i].name);
    end

    // MTHI / MTLO direct writes.
    mt("mthi", OP_MTHI, 32'hAAAA_5555);
    mt("mtlo", OP_MTLO, 32'h0000_1234);

    // MTHI held on the inputs during RUN is ignored.
    start_iter("mul_noise", OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_noise", 32'd1, 32'd0, 1'b1);
    finish_idle("mul_noise");

    // Reset at iteration 10 of MULTU 3x5, then rerun.
    start_iter("mul_rst", OP_MULTU, 32'd3, 32'd5);
    repeat (10) step();
    rst_i = 1'b0;
    #1;
    check("midrst state", 64'(state_o), 64'(S_IDLE));
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst stall", 64'(stall_o), 64'd0);
    check("midrst done", 64'(done_o), 64'd0);
    check("midrst hi", 64'(hi_o), 64'd0);
    check("midrst lo", 64'(lo_o), 64'd0);
    model_hi = '0; model_lo = '0; model_dbz = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    start_iter("mul_3x5", OP_MULTU, 32'd3, 32'd5);
    wait_done("mul_3x5", 32'd0, 32'd15, 1'b0);
    finish_idle("mul_3x5");

    // Back-to-back: DIVU issued in the DONE cycle of MULTU 6x7.
    start_iter("b2b_mul", OP_MULTU, 32'd6, 32'd7);
    wait_done("b2b_mul", 32'd0, 32'd42, 1'b0);
    start_iter("b2b_div", OP_DIVU, 32'd50, 32'd8);
    wait_done("b2b_div", 32'd2, 32'd6, 1'b0);
    finish_idle("b2b_div");

    // MTHI issued in DONE overrides the fresh HI, LO keeps the product.
    start_iter("done_mthi_mul", OP_MULTU, 32'h0000_0123, 32'h0000_0456);
    wait_done("done_mthi_mul", 32'd0, 32'h0004_EDC2, 1'b0);
    mt("done_mthi", OP_MTHI, 32'hCAFE_F00D);

    // Randomized ops against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel < 2) begin
        mt("rnd_mt", (sel == 0) ? OP_MTHI : OP_MTLO, a);
      end else begin
        op = (sel < 6) ? OP_MULTU : OP_DIVU;
        if (sel == 9) b = '0;
        else if (sel == 8) b = 32'($urandom_range(1, 300));
        r = ref_result(op, a, b);
        start_iter("rnd_iter", op, a, b);
        wait_done("rnd_iter", r[63:32], r[31:0], 1'b0);
        finish_idle("rnd_iter");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
